// File: rtl/countdown_timer_if.sv
// Control/display bundle of the countdown timer: the control FSM drives start/cancel/pause/load_val,
// the timer returns the display bus, the run flag and the expiry pulse.
interface countdown_timer_if;
    logic       start;
    logic       cancel;
    logic       pause;
    logic [7:0] load_val;
    logic [8:0] seconds;
    logic       running;
    logic       expired;

    modport master (
        output start,
        output cancel,
        output pause,
        output load_val,
        input  seconds,
        input  running,
        input  expired
    );

    modport slave (
        input  start,
        input  cancel,
        input  pause,
        input  load_val,
        output seconds,
        output running,
        output expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer: loads a value, steps it down once per TICKS_PER_SEC cycles
// and drives a registered {valid, tens, ones} display bus plus a one-cycle expiry pulse.
module countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  tmr
);

    localparam int unsigned CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] PRESC_LAST = CW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q,   state_d;
    logic [3:0]    tens_q,    tens_d;
    logic [3:0]    ones_q,    ones_d;
    logic [CW-1:0] presc_q,   presc_d;
    logic          expired_q, expired_d;
    logic [8:0]    seconds_q, seconds_d;
    logic          running_q, running_d;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
        return (digit > 4'd9) ? 4'd9 : digit;
    endfunction

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        presc_d   = presc_q;
        expired_d = 1'b0;

        if (tmr.cancel) begin
            state_d = S_IDLE;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            presc_d = '0;
        end else if (tmr.start) begin
            state_d = S_RUN;
            tens_d  = clamp_bcd(tmr.load_val[7:4]);
            ones_d  = clamp_bcd(tmr.load_val[3:0]);
            presc_d = '0;
        end else if (state_q == S_RUN) begin
            // A load of 00 expires on the very next cycle without waiting for a tick.
            if (tens_q == 4'd0 && ones_q == 4'd0) begin
                state_d   = S_DONE;
                expired_d = 1'b1;
            end else if (!tmr.pause) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end
                    if (tens_q == 4'd0 && ones_q == 4'd1) begin
                        state_d   = S_DONE;
                        expired_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + CW'(1);
                end
            end
        end

        // Outputs are decoded from next state so they can be registered without extra latency.
        seconds_d = 9'h000;
        running_d = 1'b0;
        case (state_d)
            S_RUN: begin
                seconds_d = {1'b1, tens_d, ones_d};
                running_d = 1'b1;
            end
            S_DONE:  seconds_d = 9'h100;
            default: seconds_d = 9'h000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            presc_q   <= '0;
            expired_q <= 1'b0;
            seconds_q <= 9'h000;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
            seconds_q <= seconds_d;
            running_q <= running_d;
        end
    end

    assign tmr.seconds = seconds_q;
    assign tmr.running = running_q;
    assign tmr.expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_SEC = 4; expected values are hand-computed.
module tb_countdown_timer;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   exp_cnt;
    int   exp_base;

    countdown_timer_if tif ();

    countdown_timer #(.TICKS_PER_SEC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .tmr   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial exp_cnt = 0;
    always @(negedge clk) if (tif.expired === 1'b1) exp_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [7:0] val);
        tif.load_val = val;
        tif.start    = 1'b1;
        step(1);
        tif.start    = 1'b0;
    endtask

    task automatic abort();
        tif.cancel = 1'b1;
        step(1);
        tif.cancel = 1'b0;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        tif.start    = 1'b0;
        tif.cancel   = 1'b0;
        tif.pause    = 1'b0;
        tif.load_val = 8'h00;
        reset        = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_seconds", 32'(tif.seconds), 32'h000);
        check("rst_running", 32'(tif.running), 32'd0);
        check("rst_expired", 32'(tif.expired), 32'd0);
        step(2);
        reset = 1'b0;
        step(1);

        // Basic count from 03
        exp_base = exp_cnt;
        load(8'h03);
        check("basic_load", 32'(tif.seconds), 32'h103);
        check("basic_run", 32'(tif.running), 32'd1);
        step(3);
        check("basic_hold03", 32'(tif.seconds), 32'h103);
        step(1);
        check("basic_02", 32'(tif.seconds), 32'h102);
        step(3);
        check("basic_hold02", 32'(tif.seconds), 32'h102);
        step(1);
        check("basic_01", 32'(tif.seconds), 32'h101);
        step(4);
        check("basic_00", 32'(tif.seconds), 32'h100);
        check("basic_exp_hi", 32'(tif.expired), 32'd1);
        check("basic_run_lo", 32'(tif.running), 32'd0);
        step(1);
        check("basic_exp_lo", 32'(tif.expired), 32'd0);
        step(8);
        check("basic_done_hold", 32'(tif.seconds), 32'h100);
        check("basic_one_pulse", 32'(exp_cnt - exp_base), 32'd1);

        // BCD borrow from 10
        exp_base = exp_cnt;
        load(8'h10);
        step(4);
        check("borrow_09", 32'(tif.seconds), 32'h109);
        step(36);
        check("borrow_00", 32'(tif.seconds), 32'h100);
        check("borrow_exp", 32'(tif.expired), 32'd1);
        step(3);
        check("borrow_one_pulse", 32'(exp_cnt - exp_base), 32'd1);

        // Pause for 10 cycles starting 2 cycles after start
        load(8'h05);
        step(2);
        tif.pause = 1'b1;
        step(5);
        check("pause_run", 32'(tif.running), 32'd1);
        step(5);
        check("pause_held", 32'(tif.seconds), 32'h105);
        tif.pause = 1'b0;
        step(1);
        check("pause_13", 32'(tif.seconds), 32'h105);
        step(1);
        check("pause_14", 32'(tif.seconds), 32'h104);
        check("pause_run_after", 32'(tif.running), 32'd1);
        abort();
        check("cancel_idle", 32'(tif.seconds), 32'h000);

        // Pause in IDLE has no effect
        tif.pause = 1'b1;
        step(3);
        check("pause_idle", 32'(tif.seconds), 32'h000);
        tif.pause = 1'b0;

        // Clamp and zero load
        load(8'hAF);
        check("clamp_99", 32'(tif.seconds), 32'h199);
        exp_base = exp_cnt;
        load(8'h00);
        check("zero_load", 32'(tif.seconds), 32'h100);
        check("zero_run", 32'(tif.running), 32'd1);
        check("zero_noexp", 32'(tif.expired), 32'd0);
        step(1);
        check("zero_exp", 32'(tif.expired), 32'd1);
        check("zero_done", 32'(tif.running), 32'd0);
        step(1);
        check("zero_exp_lo", 32'(tif.expired), 32'd0);
        check("zero_one_pulse", 32'(exp_cnt - exp_base), 32'd1);

        // start + cancel together: cancel wins
        load(8'h42);
        tif.load_val = 8'h05;
        tif.start    = 1'b1;
        tif.cancel   = 1'b1;
        step(1);
        tif.start    = 1'b0;
        tif.cancel   = 1'b0;
        check("prio_sc_sec", 32'(tif.seconds), 32'h000);
        check("prio_sc_run", 32'(tif.running), 32'd0);

        // start on a tick edge reloads with no decrement
        load(8'h03);
        step(3);
        load(8'h07);
        check("tick_reload", 32'(tif.seconds), 32'h107);
        step(3);
        check("tick_fresh", 32'(tif.seconds), 32'h107);
        step(1);
        check("tick_06", 32'(tif.seconds), 32'h106);

        // cancel on the expiring tick: IDLE, no expiry
        exp_base = exp_cnt;
        load(8'h01);
        step(3);
        abort();
        check("cxl_exp_sec", 32'(tif.seconds), 32'h000);
        check("cxl_exp_flag", 32'(tif.expired), 32'd0);
        step(2);
        check("cxl_no_pulse", 32'(exp_cnt - exp_base), 32'd0);

        // Asynchronous reset mid-count
        load(8'h03);
        step(4);
        check("rmid_02", 32'(tif.seconds), 32'h102);
        step(1);
        #2 reset = 1'b1;
        #1;
        check("rmid_sec", 32'(tif.seconds), 32'h000);
        check("rmid_run", 32'(tif.running), 32'd0);
        check("rmid_exp", 32'(tif.expired), 32'd0);
        step(2);
        reset = 1'b0;
        exp_base = exp_cnt;
        step(12);
        check("rmid_no_pulse", 32'(exp_cnt - exp_base), 32'd0);
        check("rmid_idle", 32'(tif.seconds), 32'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
